// File: rtl/imem_fetch_ctrl_if.sv
// ============================================================================
//  Module      : imem_fetch_ctrl_if
//  Description : Loader, instruction-memory, redirect and decode channels
//                of the instruction fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_fetch_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport slave (
    input  load_valid, load_addr, load_data, mem_rdata,
    input  redirect_valid, redirect_target, inst_ready,
    output load_ready, mem_addr, mem_we, mem_wdata,
    output inst_valid, inst, inst_pc
  );

  modport master (
    output load_valid, load_addr, load_data, mem_rdata,
    output redirect_valid, redirect_target, inst_ready,
    input  load_ready, mem_addr, mem_we, mem_wdata,
    input  inst_valid, inst, inst_pc
  );
endinterface

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction memory sequencer: loader arbitration in BOOT,
//                PC-driven fetch with valid/ready output stage in RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              start,
  input  wire              halt_req,
  imem_fetch_ctrl_if.slave bus,
  output logic [1:0]       state_o,
  output logic             err_misalign,
  output logic [CNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic handshake;
  logic pc_in_range;

  assign handshake   = inst_valid_q && bus.inst_ready;
  assign pc_in_range = (pc_q[31:2] < DEPTH_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_valid_d   = inst_valid_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    bus.load_ready = 1'b0;
    bus.mem_addr   = pc_q;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 32'h0;

    // A handshake retires the output word in every state.
    if (handshake) begin
      cnt_d        = cnt_q + CNT_ONE;
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_BOOT: begin
        bus.load_ready = 1'b1;
        bus.mem_addr   = bus.load_addr;
        bus.mem_we     = bus.load_valid;
        bus.mem_wdata  = bus.load_data;
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end

      S_RUN: begin
        if (bus.redirect_valid) begin
          inst_valid_d = 1'b0;
          if (bus.redirect_target[1:0] == 2'b00) begin
            pc_d = bus.redirect_target;
          end else begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end else if (halt_req) begin
          state_d = S_HALT;
        end else if (!inst_valid_q || bus.inst_ready) begin
          if (pc_in_range) begin
            inst_d       = bus.mem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            state_d = S_HALT;
          end
        end
      end

      S_HALT: begin
        if (start) begin
          state_d      = S_BOOT;
          inst_valid_d = 1'b0;
          pc_d         = RESET_PC;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign state_o        = state_q;
  assign err_misalign   = err_q;
  assign issue_count    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Directed self-checking bench for imem_fetch_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;
  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic [1:0]  state_o;
  logic        err_misalign;
  logic [15:0] issue_count;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .DEPTH    (16),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt_req     (halt_req),
    .bus          (bus.slave),
    .state_o      (state_o),
    .err_misalign (err_misalign),
    .issue_count  (issue_count)
  );

  logic [31:0] mem  [0:15];
  logic [31:0] prog [0:15];
  int          we_count;
  int          checks;
  int          passes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: out-of-range writes are dropped, reads return 0.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_count <= we_count + 1;
      if (bus.mem_addr[31:6] == 26'h0) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = (bus.mem_addr[31:6] == 26'h0) ? mem[bus.mem_addr[5:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    we_count = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 32'h0;
      prog[i] = 32'h0;
    end
    prog[0]  = 32'h0022_1820; prog[1]  = 32'hAC01_0000;
    prog[2]  = 32'h8C24_0000; prog[3]  = 32'h1021_0001;
    prog[4]  = 32'h2042_0005; prog[5]  = 32'h0041_1822;
    prog[6]  = 32'h8C65_0004; prog[7]  = 32'hAC66_0008;
    prog[8]  = 32'h00A6_3020; prog[9]  = 32'h1000_FFFF;
    prog[10] = 32'h0000_0013;

    reset = 1'b1; start = 1'b0; halt_req = 1'b0;
    bus.load_valid = 1'b0; bus.load_addr = 32'h0; bus.load_data = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0; bus.inst_ready = 1'b0;

    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_cnt", 32'(issue_count), 32'd0);
    chk("rst_err", 32'(err_misalign), 32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Boot load of words 0..10; start coincides with the last write.
    for (int i = 0; i <= 10; i++) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = 32'(i * 4);
      bus.load_data  = prog[i];
      start          = (i == 10);
      #1;
      chk("boot_load_ready", 32'(bus.load_ready), 32'd1);
      chk("boot_mem_addr", bus.mem_addr, 32'(i * 4));
      tick();
    end
    bus.load_valid = 1'b0;
    start          = 1'b0;
    #1;
    chk("we_pulses", 32'(we_count), 32'd11);
    chk("run_entry_state", 32'(state_o), 32'd1);
    chk("run_entry_valid", 32'(bus.inst_valid), 32'd0);
    chk("run_load_ready", 32'(bus.load_ready), 32'd0);
    chk("run_mem_addr", bus.mem_addr, 32'h0);

    // Run 1: uninterrupted stream to the end of memory.
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("run1_valid", 32'(bus.inst_valid), 32'd1);
      chk("run1_inst", bus.inst, prog[k]);
      chk("run1_pc", bus.inst_pc, 32'(k * 4));
      chk("run1_cnt", 32'(issue_count), 32'(k));
    end
    tick();
    chk("end_state", 32'(state_o), 32'd2);
    chk("end_cnt", 32'(issue_count), 32'd16);
    chk("end_valid", 32'(bus.inst_valid), 32'd0);
    chk("end_mem_addr", bus.mem_addr, 32'h40);
    bus.load_valid = 1'b1;
    #1;
    chk("halt_we", 32'(bus.mem_we), 32'd0);
    chk("halt_load_ready", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    start = 1'b1;
    tick();
    chk("halt_to_boot", 32'(state_o), 32'd0);
    chk("boot_cnt_kept", 32'(issue_count), 32'd16);
    tick();
    start = 1'b0;
    #1;
    chk("run2_state", 32'(state_o), 32'd1);
    chk("run2_pc", bus.mem_addr, 32'h0);

    // Run 2: backpressure, redirects, halt with pending word.
    tick(); tick(); tick();
    chk("bp_pre_inst", bus.inst, prog[2]);
    chk("bp_pre_cnt", 32'(issue_count), 32'd18);
    bus.inst_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_inst", bus.inst, 32'h8C24_0000);
      chk("bp_pc", bus.inst_pc, 32'h8);
      chk("bp_mem_addr", bus.mem_addr, 32'hC);
      chk("bp_cnt", 32'(issue_count), 32'd18);
    end
    bus.inst_ready = 1'b1;
    tick();
    chk("bp_rel_inst", bus.inst, 32'h1021_0001);
    chk("bp_rel_pc", bus.inst_pc, 32'hC);
    chk("bp_rel_cnt", 32'(issue_count), 32'd19);

    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h14;
    tick();
    chk("redir_flush", 32'(bus.inst_valid), 32'd0);
    chk("redir_mem_addr", bus.mem_addr, 32'h14);
    chk("redir_cnt", 32'(issue_count), 32'd19);
    bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1;
    tick();
    chk("redir_inst", bus.inst, 32'h0041_1822);
    chk("redir_pc", bus.inst_pc, 32'h14);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h8;
    tick();
    chk("redir_hs_cnt", 32'(issue_count), 32'd20);
    chk("redir_hs_flush", 32'(bus.inst_valid), 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    chk("redir2_pc", bus.inst_pc, 32'h8);

    bus.inst_ready = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("hreq_state", 32'(state_o), 32'd2);
    chk("hreq_valid", 32'(bus.inst_valid), 32'd1);
    chk("hreq_inst", bus.inst, prog[2]);
    tick();
    chk("hreq_hold", 32'(bus.inst_valid), 32'd1);
    chk("hreq_cnt", 32'(issue_count), 32'd20);
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h16;
    tick();
    bus.redirect_valid = 1'b0;
    chk("hreq_drain", 32'(bus.inst_valid), 32'd0);
    chk("hreq_drain_cnt", 32'(issue_count), 32'd21);
    chk("halt_redir_ignored", 32'(err_misalign), 32'd0);
    tick();
    chk("halt_no_fetch", 32'(bus.inst_valid), 32'd0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;

    // Run 3: misaligned redirect with a same-cycle handshake.
    tick();
    chk("run3_inst", bus.inst, prog[0]);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h16;
    tick();
    bus.redirect_valid = 1'b0;
    chk("mis_err", 32'(err_misalign), 32'd1);
    chk("mis_state", 32'(state_o), 32'd2);
    chk("mis_valid", 32'(bus.inst_valid), 32'd0);
    chk("mis_cnt", 32'(issue_count), 32'd22);
    chk("mis_pc_kept", bus.mem_addr, 32'h4);
    tick();
    chk("mis_no_fetch", 32'(bus.inst_valid), 32'd0);
    start = 1'b1;
    tick();
    chk("mis_boot_state", 32'(state_o), 32'd0);
    chk("mis_boot_err", 32'(err_misalign), 32'd1);
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_cnt", 32'(issue_count), 32'd23);
    chk("pre_rst_inst", bus.inst, prog[1]);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.inst_valid), 32'd0);
    chk("arst_cnt", 32'(issue_count), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_err", 32'(err_misalign), 32'd0);
    bus.load_addr = 32'h24;
    #1;
    chk("arst_boot_mux", bus.mem_addr, 32'h24);
    @(negedge clk);
    reset = 1'b0;
    bus.load_addr = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_state", 32'(state_o), 32'd1);
    chk("post_rst_pc", bus.mem_addr, 32'h0);
    tick();
    chk("post_rst_inst", bus.inst, prog[0]);
    chk("post_rst_cnt", 32'(issue_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
